// File: rtl/xrf_retire.sv
// xrf_retire: committed (architectural) rename map with free-list release and flush restore
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_cvalid[1:0]             commit slot valid (bit0 older, bit1 younger; 2'b10 is ignored)
//   i_crd0/i_cpd0             slot0 arch destination / new physical destination
//   i_crd1/i_cpd1             slot1 arch destination / new physical destination
//   o_cready                  commits accepted this cycle (IDLE only)
//   i_flush                   single-cycle flush request, starts or restarts a restore pass
//   o_release[PLEN]           registered pulse of superseded physical registers
//   o_rs_valid/arch/preg      restore stream, one committed mapping per cycle (x1..x(XLEN-1))
//   o_restore_done            single-cycle pulse after the last streamed entry
//   o_live[PLEN]              committed-live physical mask, valid with o_restore_done
module xrf_retire #(
   parameter int XLEN   = 32,
   parameter int ROBLEN = 16,
   parameter int PLEN   = XLEN + ROBLEN,
   parameter int XBITS  = $clog2(XLEN),
   parameter int PBITS  = $clog2(PLEN)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_cvalid,
   input  logic [XBITS-1:0] i_crd0,
   input  logic [PBITS-1:0] i_cpd0,
   input  logic [XBITS-1:0] i_crd1,
   input  logic [PBITS-1:0] i_cpd1,
   output logic             o_cready,
   input  logic             i_flush,
   output logic [PLEN-1:0]  o_release,
   output logic             o_rs_valid,
   output logic [XBITS-1:0] o_rs_arch,
   output logic [PBITS-1:0] o_rs_preg,
   output logic             o_restore_done,
   output logic [PLEN-1:0]  o_live
);
   typedef enum logic {S_IDLE, S_RESTORE} state_t;
   state_t           r_state, w_nstate;
   logic [PBITS-1:0] r_map [XLEN];
   logic [XBITS-1:0] r_idx;
   logic [PLEN-1:0]  r_release, r_live;
   logic             r_done;
   logic             w_c0, w_c1, w_last;
   logic [PBITS-1:0] w_old0, w_old1;
   logic [PLEN-1:0]  w_rel, w_live_bit;

   // Slot1 only commits alongside slot0; the lone-younger encoding is dropped.
   assign w_c0   = o_cready & i_cvalid[0];
   assign w_c1   = o_cready & i_cvalid[0] & i_cvalid[1];
   assign w_last = r_idx == XBITS'(XLEN - 1);
   // Same-rd pair: slot1 supersedes slot0's new register, not the stale table entry.
   assign w_old0 = r_map[i_crd0];
   assign w_old1 = (w_c0 && i_crd1 == i_crd0) ? i_cpd0 : r_map[i_crd1];
   assign w_rel  = ((w_c0 && i_crd0 != '0 && w_old0 != '0) ? PLEN'(1) << w_old0 : '0) |
                   ((w_c1 && i_crd1 != '0 && w_old1 != '0) ? PLEN'(1) << w_old1 : '0);
   assign w_live_bit = PLEN'(1) << r_map[r_idx];

   assign o_release      = r_release;
   assign o_restore_done = r_done;
   assign o_live         = r_live;
   assign o_rs_arch      = o_rs_valid ? r_idx : '0;
   assign o_rs_preg      = o_rs_valid ? r_map[r_idx] : '0;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_nstate;

   // A flush during RESTORE keeps the state and restarts the index, so no done pulse.
   always_comb begin
      w_nstate   = r_state;
      o_cready   = 1'b0;
      o_rs_valid = 1'b0;
      if (r_state == S_IDLE) begin
         o_cready = 1'b1;
         if (i_flush) w_nstate = S_RESTORE;
      end else begin
         o_rs_valid = 1'b1;
         if (!i_flush && w_last) w_nstate = S_IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         for (int i = 0; i < XLEN; i++) r_map[i] <= '0;
         r_idx     <= '0;
         r_release <= '0;
         r_live    <= '0;
         r_done    <= 1'b0;
      end else begin
         r_release <= w_rel;
         r_done    <= 1'b0;
         // Slot1 is written last so it wins when both slots target the same register.
         if (w_c0 && i_crd0 != '0) r_map[i_crd0] <= i_cpd0;
         if (w_c1 && i_crd1 != '0) r_map[i_crd1] <= i_cpd1;
         if (i_flush) begin
            r_idx  <= XBITS'(1);
            r_live <= '0;
         end else if (r_state == S_RESTORE) begin
            r_idx  <= r_idx + XBITS'(1);
            r_live <= r_live | w_live_bit | (w_last ? PLEN'(1) : '0);
            r_done <= w_last;
         end
      end
endmodule

// File: tb/tb_xrf_retire.sv
// tb_xrf_retire: self-checking bench for xrf_retire
module tb_xrf_retire;
   localparam int XL = 32, PL = 48, XB = 5, PB = 6;
   typedef struct {
      logic [1:0]    cv;
      logic [XB-1:0] rd0;
      logic [PB-1:0] pd0;
      logic [XB-1:0] rd1;
      logic [PB-1:0] pd1;
      logic [PL-1:0] rel;
   } vec_t;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic [1:0]    cv;
   logic [XB-1:0] rd0, rd1;
   logic [PB-1:0] pd0, pd1;
   logic          flush;
   logic          o_cready, o_rs_valid, o_restore_done;
   logic [PL-1:0] o_release, o_live;
   logic [XB-1:0] o_rs_arch;
   logic [PB-1:0] o_rs_preg;
   int            n_tests = 0, n_fail = 0;
   logic [PL-1:0] sb[$];
   vec_t          vt[12];

   always #5 clk = ~clk;

   xrf_retire dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cvalid(cv),
      .i_crd0(rd0), .i_cpd0(pd0), .i_crd1(rd1), .i_cpd1(pd1),
      .o_cready(o_cready), .i_flush(flush), .o_release(o_release),
      .o_rs_valid(o_rs_valid), .o_rs_arch(o_rs_arch), .o_rs_preg(o_rs_preg),
      .o_restore_done(o_restore_done), .o_live(o_live)
   );

   function automatic logic [PL-1:0] b(input int n);
      return PL'(1) << n;
   endfunction

   function automatic vec_t mk(input logic [1:0] c, input logic [XB-1:0] r0, input logic [PB-1:0] p0,
                               input logic [XB-1:0] r1, input logic [PB-1:0] p1, input logic [PL-1:0] r);
      vec_t v;
      v.cv = c; v.rd0 = r0; v.pd0 = p0; v.rd1 = r1; v.pd1 = p1; v.rel = r;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      cv = 2'b00; rd0 = '0; pd0 = '0; rd1 = '0; pd1 = '0; flush = 1'b0;
   endtask

   task automatic do_reset;
      idle_in;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      step;
   endtask

   task automatic apply(input vec_t v, input string name);
      cv = v.cv; rd0 = v.rd0; pd0 = v.pd0; rd1 = v.rd1; pd1 = v.pd1;
      sb.push_back(v.rel);
      step;
      idle_in;
      check(name, o_release, sb.pop_front());
   endtask

   // Called one cycle into RESTORE (index 1 showing); walks the full pass.
   task automatic restore_pass(input logic [PB-1:0] p1, input logic [PB-1:0] p2, input logic [PL-1:0] live);
      for (int k = 1; k < XL; k++) begin
         check($sformatf("stream_%0d", k), {o_cready, o_rs_valid, o_restore_done, o_rs_arch, o_rs_preg},
               {1'b0, 1'b1, 1'b0, XB'(k), (k == 1) ? p1 : (k == 2) ? p2 : PB'(0)});
         step;
      end
      check("done_pulse", {o_restore_done, o_cready, o_rs_valid}, 3'b110);
      check("done_live", o_live, live);
      step;
      check("done_clear", o_restore_done, 1'b0);
      check("live_hold", o_live, live);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      int ndone, at;
      idle_in;
      #12;
      check("rst_release", o_release, '0);
      check("rst_live", o_live, '0);
      check("rst_flags", {o_rs_valid, o_restore_done, o_cready}, 3'b001);
      step;
      rst_n = 1'b1;
      step;
      check("cready_idle", o_cready, 1'b1);

      vt[0]  = mk(2'b01, 5, 33, 0, 0, '0);
      vt[1]  = mk(2'b01, 5, 40, 0, 0, b(33));
      vt[2]  = mk(2'b00, 0, 0, 0, 0, '0);
      vt[3]  = mk(2'b11, 3, 20, 4, 21, '0);
      vt[4]  = mk(2'b11, 3, 34, 4, 35, b(20) | b(21));
      vt[5]  = mk(2'b01, 7, 22, 0, 0, '0);
      vt[6]  = mk(2'b11, 7, 36, 7, 37, b(22) | b(36));
      vt[7]  = mk(2'b01, 0, 41, 0, 0, '0);
      vt[8]  = mk(2'b10, 9, 43, 9, 42, '0);
      vt[9]  = mk(2'b01, 9, 44, 0, 0, '0);
      vt[10] = mk(2'b01, 7, 45, 0, 0, b(37));
      vt[11] = mk(2'b11, 3, 46, 4, 47, b(34) | b(35));
      for (int i = 0; i < 12; i++) apply(vt[i], $sformatf("release_vec%0d", i));

      do_reset;
      apply(mk(2'b01, 1, 10, 0, 0, '0), "setup_x1");
      cv = 2'b01; rd0 = 2; pd0 = 11; flush = 1'b1;
      sb.push_back('0);
      step;
      idle_in;
      check("flush_commit_rel", o_release, sb.pop_front());
      restore_pass(10, 11, b(0) | b(10) | b(11));

      flush = 1'b1;
      step;
      flush = 1'b0;
      repeat (14) step;
      check("abort_idx", {o_rs_valid, o_rs_arch}, {1'b1, XB'(15)});
      flush = 1'b1;
      step;
      flush = 1'b0;
      check("restart_idx", {o_rs_valid, o_rs_arch, o_rs_preg}, {1'b1, XB'(1), PB'(10)});
      ndone = 0; at = -1;
      for (int c = 0; c < 60; c++) begin
         if (o_restore_done) begin ndone++; at = c; end
         step;
      end
      check("restart_done_cnt", 32'(ndone), 32'd1);
      check("restart_done_at", 32'(at), 32'd31);
      check("restart_live", o_live, b(0) | b(10) | b(11));

      flush = 1'b1;
      step;
      flush = 1'b0;
      repeat (10) step;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_stream", {o_rs_valid, o_restore_done, o_rs_arch, o_rs_preg}, '0);
      check("async_rst_live", o_live, '0);
      check("async_rst_rel", o_release, '0);
      step;
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (o_restore_done) ndone++;
         step;
      end
      check("no_done_after_rst", 32'(ndone), 32'd0);
      flush = 1'b1;
      step;
      flush = 1'b0;
      restore_pass(0, 0, b(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/xrf_retire.md
Name: xrf_retire

Overview:
- Commit-side counterpart of the XRF rename/free-list logic.
- Holds the committed (architectural) map table, arch reg -> phys reg. Updated on in-order ROB commit, up to 2 per cycle.
- On commit, returns each superseded physical register to the free list as a one-hot release mask.
- On pipeline flush, streams the committed map back to the speculative map table and emits a live mask so the free list can be rebuilt.

Parameters:
- XLEN, 32, number of architectural registers.
- ROBLEN, 16, reorder buffer entries.
- PLEN, XLEN + ROBLEN, number of physical registers.
- XBITS, $clog2(XLEN), architectural register index width.
- PBITS, $clog2(PLEN), physical register index width.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_cvalid, in, 2: commit slot valid; bit0 = older slot, bit1 = younger slot.
- i_crd0, in, XBITS: slot0 architectural destination.
- i_cpd0, in, PBITS: slot0 new physical destination.
- i_crd1, in, XBITS: slot1 architectural destination.
- i_cpd1, in, PBITS: slot1 new physical destination.
- o_cready, out, 1: commits accepted this cycle.
- i_flush, in, 1: single-cycle flush request.
- o_release, out, PLEN: one-hot-or-two mask of physical registers freed; ORed into the free list.
- o_rs_valid, out, 1: restore stream entry valid.
- o_rs_arch, out, XBITS: restore entry architectural index.
- o_rs_preg, out, PBITS: restore entry committed physical register.
- o_restore_done, out, 1: single-cycle pulse, restore complete.
- o_live, out, PLEN: committed-live physical register mask; valid when o_restore_done = 1.

Behaviour:
- Reset (async):
  - All committed map entries = 0 (p0), matching the rename-side reset mapping.
  - State = IDLE.
  - o_release = 0, o_rs_valid = 0, o_restore_done = 0, o_live = 0, o_cready = 1 after reset release.
- States:
  - IDLE: o_cready = 1.
  - RESTORE: o_cready = 0; an index counter runs 1..XLEN-1.
- Commit handshake: a slot commits when its i_cvalid bit = 1 and o_cready = 1. Encoding rules:
  - 2'b01: slot0 only.
  - 2'b11: both slots, slot0 older.
  - 2'b10: illegal; ignored, no map or release change.
- Commit with rd == 0: no map write, no release.
- Old mapping:
  - old0 = map[rd0].
  - old1 = pd0 if slot0 commits and rd1 == rd0; otherwise map[rd1].
- Map update:
  - map[rd0] <= pd0; map[rd1] <= pd1.
  - If rd0 == rd1, slot1 wins.
- Release:
  - o_release is registered: 1 cycle after the commit edge it carries bit old0 and/or bit old1. Bits are set only for committing slots with rd != 0 and old != 0.
  - p0 is never released.
  - Otherwise o_release = 0; it is a pulse, never held.
  - If old0 == old1 (only via the same-rd case, which is not possible since old1 = pd0 there), OR semantics apply.
- Flush:
  - i_flush in IDLE: commits presented in the same cycle are accepted and applied first. The next cycle enters RESTORE with index = 1.
  - RESTORE, one entry per cycle: o_rs_valid = 1, o_rs_arch = index, o_rs_preg = map[index]. x0 is skipped.
  - Duration: XLEN-1 cycles (31 at default).
  - Live mask accumulates one bit per streamed entry, plus bit0 always set.
  - The cycle after index XLEN-1 is streamed: o_restore_done = 1 for 1 cycle, o_live = accumulated mask, state = IDLE, o_cready = 1.
  - o_live holds its value until the next restore begins; it clears at RESTORE entry.
- i_flush during RESTORE: restart at index = 1, live mask cleared, no done pulse for the aborted pass.
- No commits accepted in RESTORE; i_cvalid is ignored there.
- Async reset mid-RESTORE: immediate return to the reset state; no done pulse.

Test Plan:
1. Reset, then commit slot0 rd=5 pd=33 -> next cycle o_release=0 (old p0); map[5]=33. Then commit rd=5 pd=40 -> next cycle o_release has only bit 33 set.
2. Map x3=20, x4=21. Commit both slots: rd=3 pd=34, rd=4 pd=35 -> o_release bits {20,21}; map[3]=34, map[4]=35.
3. Map x7=22. Same-cycle commit rd=7 pd=36, rd=7 pd=37 -> o_release bits {22,36}; map[7]=37.
4. Commit rd=0 pd=41, and i_cvalid=2'b10 with rd=9 -> o_release=0; map unchanged.
5. Map x1=10, x2=11, others p0. Pulse i_flush -> o_cready=0 for 31 cycles. Stream shows arch 1->10, 2->11, 3..31->0. Then o_restore_done=1, o_live bits {0,10,11}, o_cready=1.
6. Re-assert i_flush at restore index 15 -> stream restarts at arch 1; exactly one done pulse, 31 cycles after the second flush's restore start. Separately, reset mid-restore -> all outputs 0, no done pulse.
